// File: rtl/mem_pkg.sv
// mem_pkg: constants and helpers shared by the inferred memory blocks.
//   RDW_OLD / RDW_NEW : read-during-write policy selectors.
//   lanes_of()        : number of byte lanes in a word.
//   merge_lanes()     : per-lane merge of an old and a new word under a lane mask.
//                       Operands are zero-extended to MEM_MAX_W bits by the caller
//                       and the result is cast back down to the real word width.
package mem_pkg;

  localparam int RDW_OLD   = 0;
  localparam int RDW_NEW   = 1;
  localparam int MEM_MAX_W = 1024;
  localparam int MEM_IDX_W = 10;

  function automatic int lanes_of(input int width, input int lane_width);
    return width / lane_width;
  endfunction

  // Bit b of the result comes from new_word when lane (b / lw) is enabled.
  function automatic logic [MEM_MAX_W-1:0] merge_lanes(
    input logic [MEM_MAX_W-1:0] old_word,
    input logic [MEM_MAX_W-1:0] new_word,
    input logic [MEM_MAX_W-1:0] lane_mask,
    input int                   lw
  );
    logic [MEM_MAX_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MEM_MAX_W; b++) begin
      if (lane_mask[MEM_IDX_W'(b / lw)]) merged[MEM_IDX_W'(b)] = new_word[MEM_IDX_W'(b)];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_core_be.sv
// ram_core_be: reset-free storage array with lane-enabled write and a registered,
// read-first output. Kept deliberately minimal so it maps onto block RAM with
// byte-write enables. Range checking is the caller's job.
// Ports:
//   clock      : write and read both occur on its rising edge
//   i_we       : write enable (address already known to be in range)
//   i_wr_addr  : write word address
//   i_lane_en  : per-lane write enable
//   i_wdata    : write data
//   i_re       : read enable (address already known to be in range)
//   i_rd_addr  : read word address
//   o_rdata    : read data, holds when i_re is low; returns the pre-write word
//                on a same-address read/write
module ram_core_be #(
  parameter  int words      = 16,
  parameter  int width      = 32,
  parameter  int addr_w     = 4,
  parameter  int lane_width = 8,
  localparam int lanes      = width / lane_width
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [addr_w-1:0] i_wr_addr,
  input  logic [lanes-1:0]  i_lane_en,
  input  logic [width-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [addr_w-1:0] i_rd_addr,
  output logic [width-1:0]  o_rdata
);

  // One narrow array per lane: each lane is an independent read-first RAM.
  for (genvar g = 0; g < lanes; g++) begin : g_lane
    logic [lane_width-1:0] r_mem [words];
    logic [lane_width-1:0] r_q;

    always_ff @(posedge clock) begin
      if (i_we && i_lane_en[g]) r_mem[i_wr_addr] <= i_wdata[g*lane_width +: lane_width];
      if (i_re)                 r_q <= r_mem[i_rd_addr];
    end

    assign o_rdata[g*lane_width +: lane_width] = r_q;
  end

endmodule

// File: rtl/pdp_ram_be.sv
// pdp_ram_be: single-clock pseudo dual-port RAM with byte-lane write enables,
// selectable read-during-write policy and an optional output register.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   rd_address   : read word address; rd_en requests a read every cycle it is high
//   wr_address   : write word address; data_valid requests a write
//   data         : write data; wr_lane_en[i] enables lane i
//   q, q_valid   : read result and its strobe
// Handshake: there is no backpressure. Every cycle rd_en is high issues one read;
// q_valid pulses for exactly one cycle when that read's result is on q, one cycle
// later (out_reg=0) or two cycles later (out_reg=1). q holds between results.
// Out-of-range writes are dropped; out-of-range reads return zero with q_valid.
module pdp_ram_be
  import mem_pkg::*;
#(
  parameter  int size       = 16,
  parameter  int width      = 32,
  parameter  int depth      = 4,
  parameter  int lane_width = 8,
  parameter  int rdw_mode   = 0,
  parameter  int out_reg    = 0,
  localparam int lanes      = lanes_of(width, lane_width)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [depth-1:0]  rd_address,
  input  logic              rd_en,
  input  logic [depth-1:0]  wr_address,
  input  logic [width-1:0]  data,
  input  logic              data_valid,
  input  logic [lanes-1:0]  wr_lane_en,
  output logic [width-1:0]  q,
  output logic              q_valid
);

  if ((width % lane_width) != 0 || size < 1 || size > (1 << depth)) begin : g_bad_geometry
    $error("pdp_ram_be: width must be a multiple of lane_width and 1 <= size <= 2**depth");
  end
  if (rdw_mode != RDW_OLD && rdw_mode != RDW_NEW) begin : g_bad_rdw
    $error("pdp_ram_be: rdw_mode must be RDW_OLD or RDW_NEW");
  end

  localparam logic [depth:0] c_size = (depth+1)'(size);

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_rd_fire;
  logic [width-1:0] w_core_q;
  logic [width-1:0] w_q1;
  logic             r_v1;
  logic             r_zero1;

  assign w_wr_ok   = data_valid && ({1'b0, wr_address} < c_size);
  assign w_rd_ok   = {1'b0, rd_address} < c_size;
  assign w_rd_fire = rd_en && w_rd_ok;

  ram_core_be #(
    .words      (size),
    .width      (width),
    .addr_w     (depth),
    .lane_width (lane_width)
  ) u_core (
    .clock     (clock),
    .i_we      (w_wr_ok),
    .i_wr_addr (wr_address),
    .i_lane_en (wr_lane_en),
    .i_wdata   (data),
    .i_re      (w_rd_fire),
    .i_rd_addr (rd_address),
    .o_rdata   (w_core_q)
  );

  // r_zero1 forces q to zero: after reset (the array output is not reset and may
  // hold stale data) and for out-of-range reads. It only changes on a new read so
  // that q holds its last value while rd_en is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_zero1 <= 1'b1;
    end else begin
      r_v1 <= rd_en;
      if (rd_en) r_zero1 <= !w_rd_ok;
    end
  end

  if (rdw_mode == RDW_NEW) begin : g_bypass
    // The array stays read-first; the written lanes are captured next to the read
    // and merged over the array output one cycle later.
    logic             w_col;
    logic             r_col1;
    logic [width-1:0] r_wdata1;
    logic [lanes-1:0] r_lane1;
    logic [lanes-1:0] w_mask;

    assign w_col = w_rd_fire && w_wr_ok && (rd_address == wr_address);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_col1   <= 1'b0;
        r_wdata1 <= '0;
        r_lane1  <= '0;
      end else if (rd_en) begin
        r_col1   <= w_col;
        r_wdata1 <= data;
        r_lane1  <= wr_lane_en;
      end
    end

    assign w_mask = r_col1 ? r_lane1 : '0;
    assign w_q1   = r_zero1 ? '0
                  : width'(merge_lanes(MEM_MAX_W'(w_core_q), MEM_MAX_W'(r_wdata1),
                                       MEM_MAX_W'(w_mask), lane_width));
  end else begin : g_no_bypass
    assign w_q1 = r_zero1 ? '0 : w_core_q;
  end

  if (out_reg != 0) begin : g_out_reg
    logic [width-1:0] r_q2;
    logic             r_v2;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_q2 <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_q2 <= w_q1;
      end
    end

    assign q       = r_q2;
    assign q_valid = r_v2;
  end else begin : g_no_out_reg
    assign q       = w_q1;
    assign q_valid = r_v1;
  end

endmodule

// File: tb/tb_pdp_ram_be.sv
// Bench for pdp_ram_be. Three instances share one stimulus stream:
//   dut0: size 16, old-data collisions, latency 1
//   dut1: size 16, write-through collisions, latency 2
//   dut2: size 12, write-through collisions, latency 1
// Each read pushes a hand-derived expected word and due cycle per instance; a
// per-instance monitor pops on q_valid and checks data and arrival cycle.
module tb_pdp_ram_be;
  localparam int W = 32;
  localparam int D = 4;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [D-1:0] rd_address = '0;
  logic [D-1:0] wr_address = '0;
  logic         rd_en = 1'b0;
  logic         data_valid = 1'b0;
  logic [W-1:0] data = '0;
  logic [L-1:0] wr_lane_en = '0;
  logic [W-1:0] q_a  [3];
  logic         qv_a [3];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pdp_ram_be #(.size(16), .width(W), .depth(D), .lane_width(8), .rdw_mode(0), .out_reg(0)) u_dut0 (
    .clock(clk), .reset(rst), .rd_address(rd_address), .rd_en(rd_en), .wr_address(wr_address),
    .data(data), .data_valid(data_valid), .wr_lane_en(wr_lane_en), .q(q_a[0]), .q_valid(qv_a[0]));
  pdp_ram_be #(.size(16), .width(W), .depth(D), .lane_width(8), .rdw_mode(1), .out_reg(1)) u_dut1 (
    .clock(clk), .reset(rst), .rd_address(rd_address), .rd_en(rd_en), .wr_address(wr_address),
    .data(data), .data_valid(data_valid), .wr_lane_en(wr_lane_en), .q(q_a[1]), .q_valid(qv_a[1]));
  pdp_ram_be #(.size(12), .width(W), .depth(D), .lane_width(8), .rdw_mode(1), .out_reg(0)) u_dut2 (
    .clock(clk), .reset(rst), .rd_address(rd_address), .rd_en(rd_en), .wr_address(wr_address),
    .data(data), .data_valid(data_valid), .wr_lane_en(wr_lane_en), .q(q_a[2]), .q_valid(qv_a[2]));

  // ---------------- scoreboard / monitors ----------------
  for (genvar k = 0; k < 3; k++) begin : g_sb
    logic [W-1:0] exp_q[$];
    int           due_q[$];

    always @(negedge clk) begin
      logic [W-1:0] e;
      int           d;
      if (due_q.size() != 0 && due_q[0] < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_q_valid dut%0d: no q_valid by cycle %0d, required at cycle %0d",
                 k, cyc, due_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (qv_a[k]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_q_valid dut%0d: q_valid=1 q=0x%08h at cycle %0d, required q_valid=0",
                   k, q_a[k], cyc);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          n_checks++;
          if (q_a[k] !== e) begin
            n_fail++;
            $display("FAIL read_data dut%0d: got 0x%08h, required 0x%08h (cycle %0d)", k, q_a[k], e, cyc);
          end
          n_checks++;
          if (d != cyc) begin
            n_fail++;
            $display("FAIL read_latency dut%0d: q_valid at cycle %0d, required cycle %0d", k, cyc, d);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic we, input logic [D-1:0] wa, input logic [W-1:0] wd,
                      input logic [L-1:0] le, input logic re, input logic [D-1:0] ra,
                      input logic [W-1:0] e0, input logic [W-1:0] e1, input logic [W-1:0] e2);
    @(posedge clk);
    #1;
    data_valid = we;
    wr_address = wa;
    data       = wd;
    wr_lane_en = le;
    rd_en      = re;
    rd_address = ra;
    // Sampled at edge cyc+1; latency counts from that edge.
    if (re) begin
      g_sb[0].exp_q.push_back(e0); g_sb[0].due_q.push_back(cyc + 1);
      g_sb[1].exp_q.push_back(e1); g_sb[1].due_q.push_back(cyc + 2);
      g_sb[2].exp_q.push_back(e2); g_sb[2].due_q.push_back(cyc + 1);
    end
  endtask

  task automatic wr(input logic [D-1:0] wa, input logic [W-1:0] wd, input logic [L-1:0] le);
    step(1'b1, wa, wd, le, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic rd(input logic [D-1:0] ra, input logic [W-1:0] e0, input logic [W-1:0] e1,
                    input logic [W-1:0] e2);
    step(1'b0, '0, '0, '0, 1'b1, ra, e0, e1, e2);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  function automatic logic [W-1:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b ^ 8'h5A, b, 8'hC0 | b, ~b};
  endfunction

  // Contents after the directed writes below (addr 3, 5, 7 overwritten).
  function automatic logic [W-1:0] stream_word(input int a);
    case (a)
      3:       return 32'hDEADBEEF;
      5:       return 32'h11BB33DD;
      7:       return 32'h0000F00D;
      default: return pat(a);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_q_dut%0d", k), q_a[k], '0);
      check($sformatf("reset_q_valid_dut%0d", k), W'(qv_a[k]), '0);
    end
    @(negedge clk) rst = 1'b0;

    for (int a = 0; a < 16; a++) wr(4'(a), pat(a), 4'hF);
    wr(4'd5, 32'h11223344, 4'hF);
    wr(4'd7, 32'h00000000, 4'hF);
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    rd(4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);

    // Lanes 0 and 2 written: 0x11223344 / 0xAABBCCDD -> 0x11BB33DD.
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    rd(4'd5, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

    // Collision on addr 7 (holds 0): old data for dut0, merged word for dut1/dut2.
    step(1'b1, 4'd7, 32'hCAFEF00D, 4'b0011, 1'b1, 4'd7, 32'h00000000, 32'h0000F00D, 32'h0000F00D);
    rd(4'd7, 32'h0000F00D, 32'h0000F00D, 32'h0000F00D);

    // Streaming reads 0..15, one per cycle; dut2 returns zero above its size.
    for (int a = 0; a < 16; a++)
      rd(4'(a), stream_word(a), stream_word(a), (a >= 12) ? '0 : stream_word(a));
    repeat (4) idle();
    check("hold_q_dut0", q_a[0], pat(15));
    check("hold_q_dut1", q_a[1], pat(15));
    check("hold_q_dut2_out_of_range", q_a[2], '0);
    for (int k = 0; k < 3; k++) check($sformatf("idle_q_valid_dut%0d", k), W'(qv_a[k]), '0);

    // Out of range for dut2 only; addr 11 untouched.
    wr(4'd13, 32'h13131313, 4'hF);
    rd(4'd13, 32'h13131313, 32'h13131313, 32'h00000000);
    rd(4'd11, pat(11), pat(11), pat(11));
    // data_valid with no lanes enabled changes nothing.
    wr(4'd11, 32'hFFFFFFFF, 4'b0000);
    rd(4'd11, pat(11), pat(11), pat(11));
    repeat (3) idle();

    // Reset while a read is in flight: nothing may emerge from it.
    @(posedge clk);
    #1;
    rd_en = 1'b1;
    rd_address = 4'd3;
    @(posedge clk);
    #2;
    rst   = 1'b1;
    rd_en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midread_reset_q_dut%0d", k), q_a[k], '0);
      check($sformatf("midread_reset_q_valid_dut%0d", k), W'(qv_a[k]), '0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) idle();
    rd(4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    repeat (5) idle();

    check("scoreboard_empty_dut0", W'(g_sb[0].exp_q.size()), '0);
    check("scoreboard_empty_dut1", W'(g_sb[1].exp_q.size()), '0);
    check("scoreboard_empty_dut2", W'(g_sb[2].exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pdp_ram_be.md
Name: pdp_ram_be

Overview:
Single-clock pseudo dual-port inferred RAM: one write port with byte-lane enables, and one read port with an enable.
- Adds a configurable read-during-write collision policy and an optional output register stage.
- Provides a read-valid strobe that tracks latency.
- Serves as the generic storage primitive under FIFOs, line buffers and coefficient tables.

Parameters:
size, 16, number of words; 1 ≤ size ≤ 2**depth.
width, 32, word width in bits.
depth, 4, address width in bits.
lane_width, 8, bits per byte lane; width must be a multiple of lane_width; lanes = width/lane_width.
rdw_mode, 0, read-during-write policy at the same address: 0 = old data, 1 = new data (write-through).
out_reg, 0, 1 adds an output register stage, so read latency goes from 1 to 2.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
rd_address  input  depth  read word address.
rd_en  input  1  read request; sampled every cycle.
wr_address  input  depth  write word address.
data  input  width  write data.
data_valid  input  1  write request.
wr_lane_en  input  lanes  per-lane write enable; bit i covers data[i*lane_width +: lane_width].
q  output  width  read data.
q_valid  output  1  high for exactly one cycle when q carries the result of a read.

Behaviour:
- Reset (async assert, release synchronous to clock):
  - q = 0, q_valid = 0, all pipeline and bypass registers = 0.
  - RAM contents are not reset and are undefined until written.
- Write:
  - Occurs when data_valid=1 and wr_address < size.
  - Each lane i is updated only when wr_lane_en[i]=1.
  - data_valid=1 with wr_lane_en all zero has no effect.
  - wr_address ≥ size: the write is dropped silently.
- Read:
  - rd_en=1 at edge N → q/q_valid valid after edge N+1 when out_reg=0, after edge N+2 when out_reg=1.
  - rd_en=0: q holds its last value and q_valid=0.
  - Reads are fully pipelined at one per cycle, with no bubbles.
  - rd_address ≥ size: q = 0, q_valid = 1.
- Collision: rd_en=1, data_valid=1 and rd_address==wr_address (< size) in the same cycle.
  - rdw_mode=0: q returns the pre-write word.
  - rdw_mode=1: q returns the merged word. Enabled lanes come from data; disabled lanes come from the old word.
  - Implementation for rdw_mode=1: register the collision flag, data and wr_lane_en alongside the read, and merge after the array output. The array itself stays read-first so it infers block RAM.
- A write at edge N is visible to a non-colliding read issued at edge N+1 or later.
- out_reg=1: the second stage registers q and q_valid and is cleared by reset.
- Reset asserted mid-read: in-flight reads are discarded and q_valid stays 0 until a new rd_en after release.
- Simulation elaboration check: flag an error when width % lane_width ≠ 0 or size > 2**depth.

Decomposition:
- Shared package mem_pkg:
  - constants RDW_OLD=0, RDW_NEW=1.
  - function lanes_of(width, lane_width).
  - function for the byte-merge of old/new words under a lane mask, shared with other mem blocks.
- Sub-module ram_core_be: reset-free array with lane-enabled write and registered read-first output, kept minimal for inference.
- pdp_ram_be adds:
  - range checks.
  - collision bypass.
  - valid pipeline.
  - optional output stage.

Test Plan:
- Reset then single reads: out_reg=0; write 0xDEADBEEF to addr 3 (lanes 1111); rd_en addr 3 next cycle → q=0xDEADBEEF with q_valid one cycle after rd_en. With out_reg=1, the same result arrives two cycles after rd_en.
- Lane enables: addr 5 holds 0x11223344; write 0xAABBCCDD with lanes 0101 → read gives 0x11BB33DD.
- Collision: addr 7 holds 0x0; same-cycle write 0xCAFEF00D lanes 0011 plus read addr 7 → rdw_mode=0 gives q=0x00000000; rdw_mode=1 gives q=0x0000F00D. The next read gives 0x0000F00D in both modes.
- Back-to-back streaming: reads of addrs 0..15 on 16 consecutive cycles → 16 consecutive q_valid pulses with the matching data in order, no gaps.
- Out of range, size=12, depth=4: a write to addr 13 is dropped; a read of addr 13 → q=0, q_valid=1; addr 11 is unaffected.
- Async reset mid-read: assert reset between rd_en and its q_valid → q=0 and q_valid=0 immediately. After release, no stale q_valid appears and RAM contents are retained.
